writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the 3-stage RISC-V core. It is the writer side of the register-file write port that the decode stage drives into `reg_file` (`wr_en`/`Addr_D`/`Data_D`).
- Captures the executed instruction, its ALU result and PC each cycle.
- Aligns and extends synchronous data-memory read data and selects the writeback source.
- Maintains the retired-instruction counter.

Parameters:
- PC_W, 14, width of PC_addr ports (byte address)
- XLEN, 32, datapath width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Inst_Execute  in  32  instruction leaving execute
- PC_addr_Execute  in  PC_W  PC of that instruction
- ALU_Result  in  XLEN  execute result; also the dmem address for loads
- Valid_Execute  in  1  1 = real instruction, 0 = bubble
- flush  in  1  kill the instruction being captured this edge
- dmem_dout  in  XLEN  sync-read BRAM data; valid the cycle after the address was presented
- wr_en  out  1  register-file write enable
- Addr_D  out  5  destination register
- Data_D  out  XLEN  writeback data
- Inst_WB  out  32  instruction currently in writeback
- instret  out  64  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset state (async on rst_n low): pipeline registers (inst, pc, alu, valid) = 0; instret = 0.
  - Outputs during reset: wr_en = 0, Addr_D = 0, Data_D = 0, Inst_WB = 0.
  - Reset mid-operation discards the in-flight instruction; no write occurs.
- Capture, at posedge clk:
  - inst_r <= Inst_Execute; pc_r <= PC_addr_Execute; alu_r <= ALU_Result.
  - valid_r <= Valid_Execute & ~flush.
  - No stall input: the stage always drains; upstream inserts bubbles.
- Latency: one cycle. Outputs are combinational from registered state plus dmem_dout in the cycle after capture.
- Opcode classes (inst_r[6:0]):
  - LOAD 0000011: src = MEM.
  - JAL 1101111, JALR 1100111: src = PC4.
  - LUI 0110111, AUIPC 0010111, OP 0110011, OP-IMM 0010011: src = ALU.
  - STORE, BRANCH, SYSTEM, any other opcode: no write.
- wr_en = valid_r & writes(opcode) & (inst_r[11:7] != 0). A write to x0 is never asserted.
- Addr_D = inst_r[11:7] always, even when wr_en = 0.
- Data_D by source:
  - ALU: alu_r.
  - PC4: zero-extend(pc_r) + 4, computed at XLEN. pc_r = 0x3FFC gives 0x00004000; no wrap.
  - MEM: load-extend(dmem_dout, funct3 = inst_r[14:12], off = alu_r[1:0]):
    - LB 000: byte off, sign-extended.
    - LBU 100: byte off, zero-extended.
    - LH 001: halfword off[1], sign-extended; off[0] ignored.
    - LHU 101: halfword off[1], zero-extended; off[0] ignored.
    - LW 010 and undefined 011/110/111: full word, offset ignored.
  - No-write cases: Data_D = alu_r (don't-care, but deterministic).
- Inst_WB = inst_r; it is 0 after reset.
- instret: increments by 1 on the posedge following any cycle with valid_r = 1, writing or not. Wraps 2^64-1 -> 0.
- Simultaneous events:
  - flush with Valid_Execute = 1: captured as a bubble; instret is not counted for it.
  - Decode reading Addr_D in the same cycle as wr_en sees the old value; forwarding belongs to decode, not this block.

Decomposition:
- Shared package riscv_pkg: opcode constants (OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM), load funct3 constants (F3_LB..F3_LHU), and the writeback-source enum (WB_ALU, WB_MEM, WB_PC4).
- One combinational sub-module, load_extend: inputs dmem_dout, funct3, off; output XLEN result. The verification bench exercises it standalone as well.

Test Plan:
- rst_n low mid-stream with a valid ADDI captured -> wr_en = 0, Inst_WB = 0, instret = 0 immediately. After release, the first valid instruction writes one cycle after capture.
- ADDI x5 (0x00A00293), ALU_Result = 0x0000000A, valid -> next cycle wr_en = 1, Addr_D = 5, Data_D = 0x0000000A; instret = 1 one edge later.
- LB x6 with ALU_Result = 0x103, dmem_dout = 0x80123456 -> Data_D = 0xFFFFFF80.
  - Same stimulus as LBU -> 0x00000080.
  - LH with offset 2 -> 0xFFFF8012.
  - LW -> 0x80123456.
- JAL x1 at PC 0x0100 -> Data_D = 0x00000104.
  - JALR at PC 0x3FFC -> Data_D = 0x00004000.
- ADDI x0 and a STORE, both valid -> wr_en stays 0; instret still increments by 2.
- Valid ADDI x7 with flush = 1 on its capture edge -> wr_en = 0 and no instret increment. A following valid instruction writes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants for the writeback path.
// Contents: opcode and load funct3 constants, the writeback-source enum,
// and a helper that maps an opcode to its writeback source.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // WB_NONE covers stores, branches, system and unknown opcodes.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_src_t;

  function automatic wb_src_t wb_src_of(input logic [6:0] opc);
    wb_src_t src;
    case (opc)
      OPC_LOAD:                               src = WB_MEM;
      OPC_JAL, OPC_JALR:                      src = WB_PC4;
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM:  src = WB_ALU;
      default:                                src = WB_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Purpose: select and sign/zero-extend the addressed byte/halfword of a load word.
// Latency: purely combinational.
// Backpressure: none; no handshake, result follows inputs.
// Ports: dmem_dout (raw word), funct3 (load type), off (byte offset), result (extended data).
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] dmem_dout,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dmem_dout[7:0];
    case (off)
      2'd0: byte_sel = dmem_dout[7:0];
      2'd1: byte_sel = dmem_dout[15:8];
      2'd2: byte_sel = dmem_dout[23:16];
      2'd3: byte_sel = dmem_dout[31:24];
      default: byte_sel = dmem_dout[7:0];
    endcase
    // Halfword loads ignore off[0]; misaligned halves are not split.
    half_sel = off[1] ? dmem_dout[31:16] : dmem_dout[15:0];
  end

  always_comb begin
    result = dmem_dout;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      // LW and the undefined encodings return the full word.
      default: result = dmem_dout;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Purpose: final pipeline stage; drives the register-file write port and counts retired instructions.
// Latency: one cycle from capture to wr_en/Addr_D/Data_D; outputs are comb from registered state + dmem_dout.
// Backpressure: none; the stage always drains, upstream inserts bubbles.
// Ports: Inst_Execute/PC_addr_Execute/ALU_Result/Valid_Execute/flush in from execute; dmem_dout from BRAM;
//        wr_en/Addr_D/Data_D to reg_file; Inst_WB and instret as status.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int PC_W = 14,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Inst_Execute,
  input  logic [PC_W-1:0] PC_addr_Execute,
  input  logic [XLEN-1:0] ALU_Result,
  input  logic            Valid_Execute,
  input  logic            flush,
  input  logic [XLEN-1:0] dmem_dout,
  output logic            wr_en,
  output logic [4:0]      Addr_D,
  output logic [XLEN-1:0] Data_D,
  output logic [31:0]     Inst_WB,
  output logic [63:0]     instret
);

  logic [31:0]     inst_r;
  logic [PC_W-1:0] pc_r;
  logic [XLEN-1:0] alu_r;
  logic            valid_r;
  logic [63:0]     instret_r;

  wb_src_t         src;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r  <= '0;
      pc_r    <= '0;
      alu_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      inst_r  <= Inst_Execute;
      pc_r    <= PC_addr_Execute;
      alu_r   <= ALU_Result;
      valid_r <= Valid_Execute & ~flush;
    end
  end

  // Counts every instruction that reached writeback, whether or not it wrote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (valid_r) begin
      instret_r <= instret_r + 64'd1;
    end
  end

  // The load address is the ALU result, so its low bits are the byte offset.
  load_extend #(.XLEN(XLEN)) u_load_extend (
    .dmem_dout (dmem_dout),
    .funct3    (inst_r[14:12]),
    .off       (alu_r[1:0]),
    .result    (load_data)
  );

  assign src = wb_src_of(inst_r[6:0]);

  // Link address is computed at full width so PC near the top of the space does not wrap.
  assign pc4 = {{(XLEN-PC_W){1'b0}}, pc_r} + XLEN'(4);

  always_comb begin
    Data_D = alu_r;
    case (src)
      WB_MEM:  Data_D = load_data;
      WB_PC4:  Data_D = pc4;
      default: Data_D = alu_r;
    endcase
  end

  assign wr_en   = valid_r & (src != WB_NONE) & (inst_r[11:7] != 5'd0);
  assign Addr_D  = inst_r[11:7];
  assign Inst_WB = inst_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] Inst_Execute;
  logic [13:0] PC_addr_Execute;
  logic [31:0] ALU_Result;
  logic        Valid_Execute;
  logic        flush;
  logic [31:0] dmem_dout;
  logic        wr_en;
  logic [4:0]  Addr_D;
  logic [31:0] Data_D;
  logic [31:0] Inst_WB;
  logic [63:0] instret;

  logic [31:0] le_dout;
  logic [2:0]  le_f3;
  logic [1:0]  le_off;
  logic [31:0] le_result;

  int total = 0;
  int bad   = 0;

  // Reference state: what the bench believes the stage holds.
  logic [31:0] m_inst;
  logic [13:0] m_pc;
  logic [31:0] m_alu;
  logic        m_valid;
  logic [31:0] m_dout;
  logic [63:0] exp_cnt;

  writeback_stage #(.PC_W(14), .XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Inst_Execute    (Inst_Execute),
    .PC_addr_Execute (PC_addr_Execute),
    .ALU_Result      (ALU_Result),
    .Valid_Execute   (Valid_Execute),
    .flush           (flush),
    .dmem_dout       (dmem_dout),
    .wr_en           (wr_en),
    .Addr_D          (Addr_D),
    .Data_D          (Data_D),
    .Inst_WB         (Inst_WB),
    .instret         (instret)
  );

  load_extend #(.XLEN(32)) u_le (
    .dmem_dout (le_dout),
    .funct3    (le_f3),
    .off       (le_off),
    .result    (le_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Architectural view of writeback, from the ISA rules.
  function automatic logic writes(input logic [6:0] opc);
    return opc == 7'h03 || opc == 7'h6F || opc == 7'h67 || opc == 7'h37 ||
           opc == 7'h17 || opc == 7'h33 || opc == 7'h13;
  endfunction

  function automatic logic model_wr(input logic v, input logic [31:0] inst);
    return v && writes(inst[6:0]) && (inst[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] inst, input logic [13:0] pc,
                                             input logic [31:0] alu, input logic [31:0] dout);
    int unsigned b;
    case (inst[6:0])
      7'h03: begin
        case (inst[14:12])
          3'd0: begin b = (dout >> (8 * alu[1:0])) & 32'hFF;   return (b >= 128)   ? b - 256   : b; end
          3'd4: begin b = (dout >> (8 * alu[1:0])) & 32'hFF;   return b; end
          3'd1: begin b = (dout >> (16 * alu[1])) & 32'hFFFF;  return (b >= 32768) ? b - 65536 : b; end
          3'd5: begin b = (dout >> (16 * alu[1])) & 32'hFFFF;  return b; end
          default: return dout;
        endcase
      end
      7'h6F, 7'h67: return 32'(pc) + 32'd4;
      default: return alu;
    endcase
  endfunction

  // Drive one instruction, capture it, then present the BRAM word for it.
  task automatic step(input logic [31:0] inst, input logic [13:0] pc, input logic [31:0] alu,
                      input logic v, input logic f, input logic [31:0] dout);
    @(negedge clk);
    Inst_Execute = inst; PC_addr_Execute = pc; ALU_Result = alu;
    Valid_Execute = v; flush = f;
    @(posedge clk);
    exp_cnt = exp_cnt + 64'(m_valid);
    m_valid = v & ~f; m_inst = inst; m_pc = pc; m_alu = alu; m_dout = dout;
    #1 dmem_dout = dout;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wr_en"},   64'(wr_en),   64'(model_wr(m_valid, m_inst)));
    chk({tag, ".Addr_D"},  64'(Addr_D),  64'(m_inst[11:7]));
    chk({tag, ".Data_D"},  64'(Data_D),  64'(model_data(m_inst, m_pc, m_alu, m_dout)));
    chk({tag, ".Inst_WB"}, 64'(Inst_WB), 64'(m_inst));
    chk({tag, ".instret"}, instret,      exp_cnt);
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [13:0] pc;
    logic [31:0] alu;
    logic        v;
    logic        f;
    logic [31:0] dout;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[13];

  localparam int NOPC = 11;
  logic [6:0] opcs[NOPC];

  initial begin
    logic [63:0] snap;
    logic [31:0] r;

    tbl[0]  = '{"addi_x5",   32'h00A00293, 14'h0010, 32'h0000000A, 1'b1, 1'b0, 32'h0,        1'b1, 5'd5, 32'h0000000A};
    tbl[1]  = '{"lb_off3",   32'h00000303, 14'h0014, 32'h00000103, 1'b1, 1'b0, 32'h80123456, 1'b1, 5'd6, 32'hFFFFFF80};
    tbl[2]  = '{"lbu_off3",  32'h00004303, 14'h0018, 32'h00000103, 1'b1, 1'b0, 32'h80123456, 1'b1, 5'd6, 32'h00000080};
    tbl[3]  = '{"lh_off2",   32'h00001303, 14'h001C, 32'h00000102, 1'b1, 1'b0, 32'h80123456, 1'b1, 5'd6, 32'hFFFF8012};
    tbl[4]  = '{"lw",        32'h00002303, 14'h0020, 32'h00000103, 1'b1, 1'b0, 32'h80123456, 1'b1, 5'd6, 32'h80123456};
    tbl[5]  = '{"lhu_off1",  32'h00005303, 14'h0024, 32'h00000101, 1'b1, 1'b0, 32'h80123456, 1'b1, 5'd6, 32'h00003456};
    tbl[6]  = '{"jal_x1",    32'h000000EF, 14'h0100, 32'h0000DEAD, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1, 32'h00000104};
    tbl[7]  = '{"jalr_top",  32'h000080E7, 14'h3FFC, 32'h0000BEEF, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1, 32'h00004000};
    tbl[8]  = '{"addi_x0",   32'h00A00013, 14'h0104, 32'h0000000A, 1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0000000A};
    tbl[9]  = '{"store",     32'h00112223, 14'h0108, 32'h00000044, 1'b1, 1'b0, 32'h0,        1'b0, 5'd4, 32'h00000044};
    tbl[10] = '{"addi_flush",32'h00100393, 14'h010C, 32'h00000001, 1'b1, 1'b1, 32'h0,        1'b0, 5'd7, 32'h00000001};
    tbl[11] = '{"lui_x9",    32'h123454B7, 14'h0110, 32'h12345000, 1'b1, 1'b0, 32'h0,        1'b1, 5'd9, 32'h12345000};
    tbl[12] = '{"bubble",    32'h00A00293, 14'h0114, 32'h00000055, 1'b0, 1'b0, 32'h0,        1'b0, 5'd5, 32'h00000055};

    opcs = '{7'h03, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13, 7'h23, 7'h63, 7'h73, 7'h7F};

    rst_n = 1'b0;
    Inst_Execute = '0; PC_addr_Execute = '0; ALU_Result = '0;
    Valid_Execute = 1'b0; flush = 1'b0; dmem_dout = '0;
    le_dout = '0; le_f3 = '0; le_off = '0;
    m_inst = '0; m_pc = '0; m_alu = '0; m_valid = 1'b0; m_dout = '0; exp_cnt = '0;

    // Standalone load extender against the reference model.
    for (int i = 0; i < 40; i++) begin
      le_dout = $urandom();
      r = $urandom();
      le_f3 = r[2:0];
      le_off = r[4:3];
      #1;
      chk("load_extend", 64'(le_result),
          64'(model_data({17'd0, le_f3, 5'd0, 7'h03}, 14'd0, {30'd0, le_off}, le_dout)));
    end

    // Reset state.
    @(negedge clk);
    chk("rst.wr_en",   64'(wr_en),   64'd0);
    chk("rst.Addr_D",  64'(Addr_D),  64'd0);
    chk("rst.Data_D",  64'(Data_D),  64'd0);
    chk("rst.Inst_WB", 64'(Inst_WB), 64'd0);
    chk("rst.instret", instret,      64'd0);
    rst_n = 1'b1;

    // Directed vector table.
    foreach (tbl[i]) begin
      step(tbl[i].inst, tbl[i].pc, tbl[i].alu, tbl[i].v, tbl[i].f, tbl[i].dout);
      chk({tbl[i].name, ".wr_en"},  64'(wr_en),  64'(tbl[i].e_wr));
      chk({tbl[i].name, ".Addr_D"}, 64'(Addr_D), 64'(tbl[i].e_addr));
      chk({tbl[i].name, ".Data_D"}, 64'(Data_D), 64'(tbl[i].e_data));
      chk({tbl[i].name, ".instret"}, instret, exp_cnt);
    end

    // ADDI x0 then STORE: no writes, but both retire.
    step(32'h00A00013, 14'h0200, 32'h0000000A, 1'b1, 1'b0, 32'h0);
    snap = instret;
    chk("x0.wr_en", 64'(wr_en), 64'd0);
    step(32'h00112223, 14'h0204, 32'h00000010, 1'b1, 1'b0, 32'h0);
    chk("st.wr_en", 64'(wr_en), 64'd0);
    step(32'h00000013, 14'h0208, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("x0_st.instret_plus2", instret, snap + 64'd2);

    // Flushed ADDI x7 then a real ADDI x5: flushed one is neither written nor counted.
    step(32'h00A00293, 14'h0300, 32'h0000000A, 1'b1, 1'b0, 32'h0);
    step(32'h00100393, 14'h0304, 32'h00000001, 1'b1, 1'b1, 32'h0);
    snap = instret;
    chk("flush.wr_en", 64'(wr_en), 64'd0);
    step(32'h00A00293, 14'h0308, 32'h0000000A, 1'b1, 1'b0, 32'h0);
    chk("after_flush.wr_en",   64'(wr_en),  64'd1);
    chk("after_flush.Data_D",  64'(Data_D), 64'h0000000A);
    chk("flush.no_count",      instret,     snap);

    // Async reset mid-stream with a valid ADDI in writeback.
    step(32'h00A00293, 14'h0400, 32'h0000000A, 1'b1, 1'b0, 32'h0);
    chk("pre_rst.wr_en", 64'(wr_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst.wr_en",   64'(wr_en),   64'd0);
    chk("mid_rst.Inst_WB", 64'(Inst_WB), 64'd0);
    chk("mid_rst.instret", instret,      64'd0);
    m_inst = '0; m_pc = '0; m_alu = '0; m_valid = 1'b0; exp_cnt = '0;
    Valid_Execute = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h00A00293, 14'h0404, 32'h0000000A, 1'b1, 1'b0, 32'h0);
    chk("post_rst.wr_en",  64'(wr_en),  64'd1);
    chk("post_rst.Addr_D", 64'(Addr_D), 64'd5);
    step(32'h00000013, 14'h0408, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_rst.instret", instret, 64'd1);

    // Randomized stream against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      logic [13:0] pc;
      logic [31:0] rv;
      r = $urandom();
      inst = {r[31:7], opcs[$urandom_range(NOPC - 1, 0)]};
      rv = $urandom();
      pc = (rv[3:0] == 4'd0) ? 14'h3FFC : rv[17:4];
      step(inst, pc, $urandom(), rv[20] | rv[21], (rv[24:22] == 3'd0), $urandom());
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
